// File: rtl/muldiv_unit_if.sv
//------------------------------------------------------------------------------
// muldiv_unit_if
//   Issue/result bundle between the issuing control and the multiply/divide
//   unit. The issuer (master) drives the operation request, operands and the
//   MTHI/MTLO writes; the unit (slave) returns busy/done and the HI/LO values.
//
//   Signals
//     start  issue the operation selected by op (honoured only when idle)
//     op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     a      rs value: multiplicand / dividend / MTHI-MTLO data
//     b      rt value: multiplier / divisor
//     mthi   write a into HI (honoured only when idle)
//     mtlo   write a into LO (honoured only when idle)
//     busy   operation in flight
//     done   one-cycle pulse, HI/LO carry the new result
//     hi/lo  HI and LO registers
//
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit that owns the HI/LO registers.
//   MULT/MULTU use a shift-add over a 2*WIDTH accumulator, DIV/DIVU use a
//   restoring shift-subtract. Each operation takes WIDTH iteration cycles plus
//   one sign-fix/writeback cycle; busy covers all of them.
//
//   Ports
//     clock  rising-edge clock
//     reset  asynchronous active-low reset, clears all state
//     bus    muldiv_unit_if.slave (start/op/a/b/mthi/mtlo in,
//            busy/done/hi/lo out)
//
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic    clock,
  input  wire logic    reset,
  muldiv_unit_if.slave bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_busy;

  // Latched operation context
  logic               r_is_div;   // divide (DIV/DIVU) vs multiply
  logic               r_neg_res;  // negate product / quotient in FIX
  logic               r_neg_rem;  // negate remainder in FIX (sign of a)
  logic               r_dvz;      // divide by zero
  logic [WIDTH-1:0]   r_a_raw;    // unmodified a, HI result on divide by zero
  logic [WIDTH-1:0]   r_opb;      // multiplicand (mul) or divisor (div), magnitude
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}
                                  // div: {partial remainder, dividend/quotient}
  logic [c_cnt_w-1:0] r_cnt;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Operand magnitudes at issue time; only signed ops take the absolute value.
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;

  // Result formatting
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  //----------------------------------------------------------------------------
  // Control FSM
  //----------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == c_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Operand conditioning
  //----------------------------------------------------------------------------
  // op[0] selects the signed variants. The magnitude of the most negative
  // value is its own bit pattern, which is the correct unsigned magnitude.
  always_comb begin
    w_abs_a = bus.a;
    w_abs_b = bus.b;
    if (bus.op[0] && bus.a[WIDTH-1]) begin
      w_abs_a = -bus.a;
    end
    if (bus.op[0] && bus.b[WIDTH-1]) begin
      w_abs_b = -bus.b;
    end
  end

  //----------------------------------------------------------------------------
  // One iteration of each algorithm
  //----------------------------------------------------------------------------
  // Multiply: add the multiplicand into the upper half when the multiplier
  // LSB is set, then shift the whole accumulator right by one. The carry of
  // the add becomes the new MSB, so no product bit is lost.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) begin
      w_mul_sum = w_mul_sum + {1'b0, r_opb};
    end
    w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  // Divide: the trial value is the partial remainder with the next dividend
  // bit shifted in. If the divisor fits, keep the difference and shift a 1
  // into the quotient; otherwise restore (just shift) and shift in a 0.
  always_comb begin
    w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    if (w_div_diff[WIDTH]) begin
      w_div_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_div_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  //----------------------------------------------------------------------------
  // Sign correction and HI/LO selection for the FIX cycle
  //----------------------------------------------------------------------------
  always_comb begin
    w_prod = r_acc;
    w_quo  = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
    if (r_neg_res) begin
      w_prod = -r_acc;
      w_quo  = -r_acc[WIDTH-1:0];
    end
    if (r_neg_rem) begin
      w_rem = -r_acc[2*WIDTH-1:WIDTH];
    end

    if (!r_is_div) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_dvz) begin
      // Divide by zero: all-ones quotient, dividend passed through untouched.
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  //----------------------------------------------------------------------------
  // Datapath and HI/LO registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dvz     <= 1'b0;
      r_a_raw   <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // start wins over MTHI/MTLO in the same cycle.
            r_is_div  <= bus.op[1];
            r_neg_res <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_rem <= bus.op[0] & bus.a[WIDTH-1];
            r_dvz     <= (bus.b == '0);
            r_a_raw   <= bus.a;
            r_cnt     <= '0;
            if (bus.op[1]) begin
              r_opb <= w_abs_b;
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opb <= w_abs_a;
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
            end
          end else begin
            if (bus.mthi) begin
              r_hi <= bus.a;
            end
            if (bus.mtlo) begin
              r_lo <= bus.a;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_is_div ? w_div_step : w_mul_step;
        end
        S_FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the HI/LO registers. It sits directly downstream of the register file and takes its two read-port outputs (rs value, rt value) as operands for MULT, MULTU, DIV and DIVU. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. A `busy` flag stalls the issuing control while a 33-cycle operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width. Only 32 is required; the iteration count equals `WIDTH`.
- `clock`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  issue the operation selected by `op`; honoured only when idle.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  rs value: multiplicand or dividend; also the MTHI/MTLO data.
- `b`  in  WIDTH  rt value: multiplier or divisor.
- `mthi`  in  1  write `a` into HI; honoured only when idle.
- `mtlo`  in  1  write `a` into LO; honoured only when idle.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi`  out  WIDTH  HI register, read directly by MFHI.
- `lo`  out  WIDTH  LO register, read directly by MFLO.

## Operation
- States: IDLE, CALC, FIX.
- Reset values (async, `reset`=0): state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; internal counters and datapath registers 0.
- IDLE with `start`=1:
  - Latch `a`, `b` and `op`.
  - For signed ops (MULT, DIV), latch absolute values and record the sign flags.
  - Go to CALC with the iteration counter = 0.
- IDLE with `start`=0:
  - `mthi`=1: HI <= `a`.
  - `mtlo`=1: LO <= `a`.
  - Both may be high in the same cycle; both writes occur.
- `start` has priority: if `start` and `mthi`/`mtlo` are high in the same cycle, the MT writes are dropped.
- `start`, `mthi` and `mtlo` are ignored whenever `busy`=1.
- CALC runs exactly WIDTH cycles, one iteration per cycle, then goes to FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and a WIDTH-bit remainder.
- FIX (1 cycle) applies sign correction and writes HI/LO, then returns to IDLE.
  - MULT: negate the 64-bit product when sign(a) XOR sign(b).
  - DIV: negate the quotient when sign(a) XOR sign(b); the remainder takes the sign of `a`.
  - Multiply result: HI = product[63:32], LO = product[31:0].
  - Divide result: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU with `b`=0):
  - Still runs the full 33 cycles.
  - Result is LO = 0xFFFFFFFF, HI = `a` unmodified. No sign correction is applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Wraps; no trap.
- While `busy`=1, `hi`/`lo` keep their previous values. Only FIX updates them.

## Timing
- Edge E0 accepts `start`.
- `busy`=1 from E0 through E33, i.e. 33 cycles: 32 CALC + 1 FIX.
- At E33:
  - HI/LO are updated and the state returns to IDLE.
  - `busy`=0 and `done`=1 for the single cycle after E33.
- A new `start` presented in the `done` cycle is accepted. Back-to-back issue period is 34 cycles.
- MTHI/MTLO take effect at the accepting edge and are visible on `hi`/`lo` the next cycle.
- Asserting `reset` mid-operation immediately aborts:
  - `busy`=0, `done`=0, `hi`=`lo`=0.
  - No partial result is written.
- Operands on `a`/`b` may change freely after E0; only the latched copies are used.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `busy` high for 33 cycles, then `done` pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a MULTU; pulse `start` (a different op) and `mthi` at cycle 10 -> both ignored, the original result is delivered at cycle 33. A new `start` in the `done` cycle is accepted and `busy` rises the next cycle.
- Idle, `mthi`=`mtlo`=1 with a=0xCAFEF00D -> hi=lo=0xCAFEF00D next cycle. Same cycle with `start`=1 -> MT writes are dropped and the operation runs.
- Start DIVU, drive `reset`=0 at cycle 15 (between edges) -> `busy`, `done`, `hi`, `lo` go to 0 without waiting for a clock edge. After release, a fresh DIVU 9/3 gives lo=3, hi=0.
